// File: rtl/memory_stage_controller.sv
// Memory-stage data-access controller: valid/ready request, rvalid response, StallM holds the pipe.
// Build option: define MISALIGN_CHECK_EN to trap misaligned accesses instead of issuing them.
module memory_stage_controller #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [3:0]        controlM,
  input  logic [ADDR_W-1:0] AluResultM,
  input  logic [DATA_W-1:0] WriteDataM,
  output logic              StallM,
  output logic [DATA_W-1:0] ReadDataM,
  output logic              MisalignM,
  output logic              mem_valid,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ready,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, DONE} state_t;

  state_t            state, state_nxt;
  logic              is_load, op, misaligned, start;
  logic              req_we;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] req_wdata;
  logic [DATA_W-1:0] rdata_q;
  logic              unused_regwrite;

  // RegWrite is a writeback concern; this stage only decodes the memory fields.
  assign unused_regwrite = controlM[3];

  // A load wins when both load and MemWrite are encoded.
  assign is_load = (controlM[2:1] == 2'b01);
  assign op      = controlM[0] | is_load;

`ifdef MISALIGN_CHECK_EN
  assign misaligned = (AluResultM[1:0] != 2'b00);
`else
  assign misaligned = 1'b0;
`endif

  assign start = (state == IDLE) && op && !misaligned;

  // State register
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  // Next-state logic
  always_comb begin
    // NOTE: default assignment first, so no path through the case leaves state_nxt unassigned (no latch).
    state_nxt = state;
    case (state)
      IDLE: if (op)         state_nxt = misaligned ? DONE : REQ;
      REQ:  if (mem_ready)  state_nxt = req_we ? DONE : RESP;
      RESP: if (mem_rvalid) state_nxt = DONE;
      DONE:                 state_nxt = IDLE;
      default:              state_nxt = IDLE;
    endcase
  end

  // Output logic; the stall is suppressed while reset is asserted.
  always_comb begin
    mem_valid = 1'b0;
    StallM    = 1'b0;
    if (reset) begin
      mem_valid = (state == REQ);
      StallM    = op && (state != DONE);
    end
  end

  // Request copies are taken once in IDLE so the bus stays stable while the slave stalls.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      req_we    <= 1'b0;
      req_addr  <= '0;
      req_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      if (start) begin
        req_we    <= !is_load;
`ifdef MISALIGN_CHECK_EN
        req_addr  <= AluResultM;
`else
        req_addr  <= AluResultM & ~{{(ADDR_W-2){1'b0}}, 2'b11};
`endif
        req_wdata <= WriteDataM;
      end
      if ((state == RESP) && mem_rvalid) rdata_q <= mem_rdata;
    end
  end

`ifdef MISALIGN_CHECK_EN
  logic misalign_q;

  // Registered so the flag lines up with the DONE cycle that follows the trapped IDLE cycle.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) misalign_q <= 1'b0;
    else        misalign_q <= (state == IDLE) && op && misaligned;
  end

  assign MisalignM = misalign_q;
`else
  assign MisalignM = 1'b0;
`endif

  assign mem_we    = req_we;
  assign mem_addr  = req_addr;
  assign mem_wdata = req_wdata;
  assign ReadDataM = rdata_q;

endmodule

// File: tb/tb_memory_stage_controller.sv
// Self-checking bench for memory_stage_controller: vector table, hand sequences, random traffic vs. a
// transaction-level model. Expectations follow MISALIGN_CHECK_EN when it is defined for the build.
module tb_memory_stage_controller;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic [3:0]  controlM = '0;
  logic [31:0] AluResultM = '0;
  logic [31:0] WriteDataM = '0;
  logic        StallM;
  logic [31:0] ReadDataM;
  logic        MisalignM;
  logic        mem_valid;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_ready = 1'b0;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;

  memory_stage_controller #(.DATA_W(32), .ADDR_W(32)) dut (
    .clock(clock), .reset(reset), .controlM(controlM), .AluResultM(AluResultM),
    .WriteDataM(WriteDataM), .StallM(StallM), .ReadDataM(ReadDataM), .MisalignM(MisalignM),
    .mem_valid(mem_valid), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ready(mem_ready), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata)
  );

  always #5 clock = ~clock;

  int n_vec = 0;
  int n_err = 0;
  logic [31:0] model_rd = '0;

`ifdef MISALIGN_CHECK_EN
  localparam bit MIS_EN = 1'b1;
`else
  localparam bit MIS_EN = 1'b0;
`endif

  typedef struct {
    logic [3:0]  ctl;
    logic [31:0] addr;
    logic [31:0] data;
    int          rdly;
    int          rvdly;
    logic [31:0] rdata;
    int          exp_stall;
    bit          exp_req;
    bit          exp_we;
    logic [31:0] exp_addr;
    logic [31:0] exp_rd;
    bit          exp_mis;
  } vec_t;

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Behavioural model of one instruction: stall length is the sum of the phase lengths.
  function automatic vec_t model(input logic [3:0] ctl, input logic [31:0] addr,
                                 input logic [31:0] data, input int rdly, input int rvdly,
                                 input logic [31:0] rdata);
    vec_t v;
    bit ld, is_op, mis;
    ld    = (ctl[2:1] == 2'b01);
    is_op = ctl[0] | ld;
    mis   = MIS_EN && is_op && (addr[1:0] != 2'b00);
    v.ctl = ctl; v.addr = addr; v.data = data; v.rdly = rdly; v.rvdly = rvdly; v.rdata = rdata;
    v.exp_req  = is_op && !mis;
    v.exp_we   = !ld;
    v.exp_addr = MIS_EN ? addr : {addr[31:2], 2'b00};
    v.exp_mis  = mis;
    if (!is_op)   v.exp_stall = 0;
    else if (mis) v.exp_stall = 1;
    else          v.exp_stall = 2 + rdly + (ld ? rvdly + 1 : 0);
    if (v.exp_req && ld) model_rd = rdata;
    v.exp_rd = model_rd;
    return v;
  endfunction

  // Drive one instruction until its DONE (StallM low) cycle while acting as the memory slave.
  task automatic run_instr(input string nm, input vec_t v);
    int cyc = 0, valid_seen = 0, acc = -1, stall_cnt = 0, reqs = 0;
    bit acc_load = 1'b0, done = 1'b0, rv_now, stray_ok;
    while (!done && cyc < 200) begin
      @(negedge clock);
      controlM   = v.ctl;
      AluResultM = v.addr;
      WriteDataM = v.data;
      mem_ready  = mem_valid && (valid_seen >= v.rdly);
      rv_now     = (acc >= 0) && acc_load && (cyc == acc + 1 + v.rvdly);
      stray_ok   = !((acc >= 0) && acc_load && (cyc <= acc + 1 + v.rvdly));
      mem_rvalid = rv_now || (stray_ok && ($urandom_range(3) == 0));
      mem_rdata  = rv_now ? v.rdata : $urandom;
      #1;
      if (mem_valid) begin
        check({nm, " mem_we"}, 32'(mem_we), 32'(v.exp_we));
        check({nm, " mem_addr"}, mem_addr, v.exp_addr);
        if (v.exp_we) check({nm, " mem_wdata"}, mem_wdata, v.data);
        valid_seen++;
        if (mem_ready) begin
          acc = cyc;
          acc_load = !mem_we;
          reqs++;
        end
      end
      if (!StallM) begin
        done = 1'b1;
        check({nm, " stall_cycles"}, 32'(stall_cnt), 32'(v.exp_stall));
        check({nm, " ReadDataM"}, ReadDataM, v.exp_rd);
        check({nm, " MisalignM"}, 32'(MisalignM), 32'(v.exp_mis));
        check({nm, " requests"}, 32'(reqs), 32'(v.exp_req));
        check({nm, " mem_valid_done"}, 32'(mem_valid), 32'd0);
      end else begin
        stall_cnt++;
      end
      cyc++;
    end
    if (!done) begin
      n_vec++;
      n_err++;
      $display("FAIL %s timeout: StallM still %b after %0d cycles, required low", nm, StallM, cyc);
    end
    mem_ready  = 1'b0;
    mem_rvalid = 1'b0;
  endtask

  vec_t tbl[10];
  vec_t rv;

  initial begin
    // Reset state, with a store op and bus activity present on the inputs.
    reset = 1'b0; controlM = 4'b0001; AluResultM = 32'h104; WriteDataM = 32'h55;
    mem_ready = 1'b1; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clock);
    #1;
    check("rst StallM", 32'(StallM), 32'd0);
    check("rst mem_valid", 32'(mem_valid), 32'd0);
    check("rst mem_we", 32'(mem_we), 32'd0);
    check("rst mem_addr", mem_addr, 32'd0);
    check("rst mem_wdata", mem_wdata, 32'd0);
    check("rst ReadDataM", ReadDataM, 32'd0);
    check("rst MisalignM", 32'(MisalignM), 32'd0);
    @(negedge clock);
    reset = 1'b1; controlM = '0; mem_ready = 1'b0; mem_rvalid = 1'b0;

    // Ten idle instructions: no stall, no request.
    for (int i = 0; i < 10; i++)
      run_instr($sformatf("nop%0d", i), model(4'b0000, 32'(i * 4), 32'h0, 0, 0, 32'h0));

    // Directed table; expectations written out from the instruction rules.
    tbl[0] = '{4'b1000, 32'h104, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,   32'h0,         0};
    tbl[1] = '{4'b0001, 32'h100, 32'hDEADBEEF,  0, 0, 32'h0,         2, 1, 1, 32'h100, 32'h0,         0};
    tbl[2] = '{4'b0010, 32'h200, 32'h0,         3, 1, 32'h12345678,  7, 1, 0, 32'h200, 32'h12345678,  0};
    tbl[3] = '{4'b1100, 32'h208, 32'h0,         0, 0, 32'h0,         0, 0, 0, 32'h0,   32'h12345678,  0};
    tbl[4] = '{4'b1011, 32'h20C, 32'hFFFF0000,  0, 0, 32'hA5A5A5A5,  3, 1, 0, 32'h20C, 32'hA5A5A5A5,  0};
    tbl[5] = '{4'b0111, 32'h210, 32'hCAFEF00D,  1, 0, 32'h0,         3, 1, 1, 32'h210, 32'hA5A5A5A5,  0};
`ifdef MISALIGN_CHECK_EN
    tbl[6] = '{4'b0010, 32'h203, 32'h0,         0, 0, 32'h0BADCAFE,  1, 0, 0, 32'h203, 32'hA5A5A5A5,  1};
    tbl[7] = '{4'b0001, 32'h40,  32'h11111111,  0, 0, 32'h0,         2, 1, 1, 32'h40,  32'hA5A5A5A5,  0};
`else
    tbl[6] = '{4'b0010, 32'h203, 32'h0,         0, 0, 32'h0BADCAFE,  3, 1, 0, 32'h200, 32'h0BADCAFE,  0};
    tbl[7] = '{4'b0001, 32'h40,  32'h11111111,  0, 0, 32'h0,         2, 1, 1, 32'h40,  32'h0BADCAFE,  0};
`endif
    tbl[8] = '{4'b0010, 32'h40,  32'h0,         0, 0, 32'h22222222,  3, 1, 0, 32'h40,  32'h22222222,  0};
`ifdef MISALIGN_CHECK_EN
    tbl[9] = '{4'b0001, 32'h102, 32'h33,        0, 0, 32'h0,         1, 0, 1, 32'h102, 32'h22222222,  1};
`else
    tbl[9] = '{4'b0001, 32'h102, 32'h33,        0, 0, 32'h0,         2, 1, 1, 32'h100, 32'h22222222,  0};
`endif
    for (int i = 0; i < 10; i++) run_instr($sformatf("vec%0d", i), tbl[i]);

    // Reset during RESP abandons the load; a later stray rvalid must not update ReadDataM.
    @(negedge clock);
    controlM = 4'b0010; AluResultM = 32'h300; mem_ready = 1'b0; mem_rvalid = 1'b0;
    #1 check("rstresp idle stall", 32'(StallM), 32'd1);
    @(negedge clock);
    mem_ready = 1'b1;
    #1 check("rstresp req valid", 32'(mem_valid), 32'd1);
    @(negedge clock);
    mem_ready = 1'b0;
    #1 check("rstresp resp stall", 32'(StallM), 32'd1);
    check("rstresp resp valid", 32'(mem_valid), 32'd0);
    #1 reset = 1'b0;
    #1 check("rstresp in-reset StallM", 32'(StallM), 32'd0);
    check("rstresp in-reset ReadDataM", ReadDataM, 32'd0);
    check("rstresp in-reset mem_addr", mem_addr, 32'd0);
    @(negedge clock);
    reset = 1'b1; controlM = 4'b0000; mem_rvalid = 1'b1; mem_rdata = 32'hBAD0BAD0;
    #1 check("rstresp post StallM", 32'(StallM), 32'd0);
    @(negedge clock);
    mem_rvalid = 1'b0;
    #1 check("rstresp post ReadDataM", ReadDataM, 32'd0);
    check("rstresp post mem_valid", 32'(mem_valid), 32'd0);
    model_rd = '0;

    // Random traffic against the model, back-to-back.
    for (int i = 0; i < 200; i++) begin
      logic [31:0] a;
      a = $urandom;
      if ($urandom_range(3) != 0) a[1:0] = 2'b00;
      rv = model(4'($urandom), a, $urandom, int'($urandom_range(3)), int'($urandom_range(3)), $urandom);
      run_instr($sformatf("rnd%0d", i), rv);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
